// File: rtl/bm_mem_pkg.sv
// rtl/bm_mem_pkg.sv - shared sizes, load FSM states and err bit indices for bm_mem
package bm_mem_pkg;

  localparam int BM_COL_W      = 256;
  localparam int BM_MEM_DEPTH  = 4;
  localparam int BM_MEM_ADDR_W = 2;
  localparam int HOST_DATA_W   = 32;

  function automatic int words_per_col(input int col_w, input int data_w);
    return (col_w + data_w - 1) / data_w;
  endfunction

  localparam int WORDS_PER_COL = words_per_col(BM_COL_W, HOST_DATA_W);
  localparam int STAGE_W       = WORDS_PER_COL * HOST_DATA_W;
  localparam int WCNT_W        = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;

  localparam int ERR_RD  = 0;
  localparam int ERR_COL = 1;
  localparam int ERR_RDY = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } ld_state_e;

  function automatic logic col_in_range(input logic [BM_MEM_ADDR_W-1:0] col);
    return int'(col) < BM_MEM_DEPTH;
  endfunction

endpackage

// File: rtl/bm_mem_col_loader.sv
// rtl/bm_mem_col_loader.sv - host column load FSM, staging register and word counter
module bm_mem_col_loader
  import bm_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_wr_en,
  input  logic [BM_MEM_ADDR_W-1:0] i_wr_col,
  input  logic [HOST_DATA_W-1:0]   i_wr_data,
  input  logic                     i_wr_abort,
  output logic                     o_wr_rdy,
  output logic                     o_col_err,
  output logic                     o_commit,
  output logic [BM_MEM_ADDR_W-1:0] o_commit_col,
  output logic [BM_COL_W-1:0]      o_commit_data
);

  ld_state_e                r_state;
  ld_state_e                w_next;
  logic [BM_MEM_ADDR_W-1:0] r_col;
  logic [WCNT_W-1:0]        r_cnt;
  logic [STAGE_W-1:0]       r_stage;
  logic                     w_first;
  logic                     w_store;
  logic                     w_clear;

  // load state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next state, ready and staging controls; abort beats a same-cycle word
  always_comb begin
    w_next    = r_state;
    w_first   = 1'b0;
    w_store   = 1'b0;
    w_clear   = 1'b0;
    o_wr_rdy  = 1'b1;
    o_col_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_wr_abort) begin
          w_clear = 1'b1;
        end else if (i_wr_en) begin
          w_first = 1'b1;
          w_next  = (WORDS_PER_COL == 1) ? COMMIT : FILL;
        end
      end
      FILL: begin
        if (i_wr_abort) begin
          w_clear = 1'b1;
          w_next  = IDLE;
        end else if (i_wr_en) begin
          if (i_wr_col != r_col) begin
            o_col_err = 1'b1;
            w_clear   = 1'b1;
            w_next    = IDLE;
          end else begin
            w_store = 1'b1;
            if (r_cnt == WCNT_W'(WORDS_PER_COL - 1)) w_next = COMMIT;
          end
        end
      end
      COMMIT: begin
        o_wr_rdy = 1'b0;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // staging register, latched column and word index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col   <= '0;
      r_cnt   <= '0;
      r_stage <= '0;
    end else if (w_clear) begin
      r_cnt   <= '0;
      r_stage <= '0;
    end else if (w_first) begin
      r_col                      <= i_wr_col;
      r_cnt                      <= WCNT_W'(1);
      r_stage                    <= '0;
      r_stage[HOST_DATA_W-1:0]   <= i_wr_data;
    end else if (w_store) begin
      r_stage[int'(r_cnt) * HOST_DATA_W +: HOST_DATA_W] <= i_wr_data;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_commit      = (r_state == COMMIT);
  assign o_commit_col  = r_col;
  assign o_commit_data = r_stage[BM_COL_W-1:0];

endmodule

// File: rtl/bm_mem.sv
// rtl/bm_mem.sv - bitmatrix column memory with host loader; BM_MEM_RD_OUT_REG_EN adds a read output stage
module bm_mem
  import bm_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     eng_rstn,
  input  logic                     bm_cntl_bm_mem_rd_rq,
  input  logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr,
  output logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data,
  output logic                     bm_mem_bm_cntl_rd_data_val,
  input  logic                     host_bm_mem_wr_en,
  input  logic [BM_MEM_ADDR_W-1:0] host_bm_mem_wr_col,
  input  logic [HOST_DATA_W-1:0]   host_bm_mem_wr_data,
  input  logic                     host_bm_mem_wr_abort,
  output logic                     bm_mem_host_wr_rdy,
  output logic [BM_MEM_DEPTH-1:0]  bm_mem_col_valid,
  input  logic                     host_bm_mem_err_clr,
  output logic [2:0]               bm_mem_err
);

  logic [BM_COL_W-1:0]      r_mem [BM_MEM_DEPTH];
  logic [BM_MEM_DEPTH-1:0]  r_col_valid;
  logic [2:0]               r_err;
  logic [2:0]               w_err_set;
  logic [BM_COL_W-1:0]      r_rd_data;
  logic                     r_rd_val;
  logic                     w_rd_req;
  logic                     w_rd_ok;
  logic                     w_wr_ok;
  logic                     w_commit;
  logic                     w_col_err;
  logic [BM_MEM_ADDR_W-1:0] w_commit_col;
  logic [BM_COL_W-1:0]      w_commit_data;

  bm_mem_col_loader u_loader (
    .clk           (clk),
    .rstn          (rstn),
    .i_wr_en       (host_bm_mem_wr_en),
    .i_wr_col      (host_bm_mem_wr_col),
    .i_wr_data     (host_bm_mem_wr_data),
    .i_wr_abort    (host_bm_mem_wr_abort),
    .o_wr_rdy      (bm_mem_host_wr_rdy),
    .o_col_err     (w_col_err),
    .o_commit      (w_commit),
    .o_commit_col  (w_commit_col),
    .o_commit_data (w_commit_data)
  );

  assign w_rd_req = bm_cntl_bm_mem_rd_rq && eng_rstn;
  assign w_rd_ok  = col_in_range(bm_cntl_bm_mem_rd_addr);
  assign w_wr_ok  = col_in_range(w_commit_col);

  // new error events this cycle
  always_comb begin
    w_err_set          = '0;
    w_err_set[ERR_RD]  = (w_rd_req && (!w_rd_ok || !r_col_valid[bm_cntl_bm_mem_rd_addr]))
                         || (w_commit && !w_wr_ok);
    w_err_set[ERR_COL] = w_col_err;
    w_err_set[ERR_RDY] = host_bm_mem_wr_en && !bm_mem_host_wr_rdy;
  end

  // column array and loaded flags, written only by a commit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BM_MEM_DEPTH; i++) r_mem[i] <= '0;
      r_col_valid <= '0;
    end else if (w_commit && w_wr_ok) begin
      r_mem[w_commit_col]       <= w_commit_data;
      r_col_valid[w_commit_col] <= 1'b1;
    end
  end

  // first read stage; a same-cycle commit is not visible until the next read
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_data <= '0;
      r_rd_val  <= 1'b0;
    end else if (w_rd_req) begin
      r_rd_data <= w_rd_ok ? r_mem[bm_cntl_bm_mem_rd_addr] : '0;
      r_rd_val  <= 1'b1;
    end else begin
      r_rd_val  <= 1'b0;
    end
  end

  // sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_err <= '0;
    else       r_err <= (host_bm_mem_err_clr ? 3'b000 : r_err) | w_err_set;
  end

`ifdef BM_MEM_RD_OUT_REG_EN
  logic [BM_COL_W-1:0] r_rd_data_q;
  logic                r_rd_val_q;

  // second read stage; engine soft reset flushes it together with the first
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_data_q <= '0;
      r_rd_val_q  <= 1'b0;
    end else begin
      r_rd_val_q <= eng_rstn && r_rd_val;
      if (eng_rstn && r_rd_val) r_rd_data_q <= r_rd_data;
    end
  end

  assign bm_mem_bm_cntl_rd_data     = r_rd_data_q;
  assign bm_mem_bm_cntl_rd_data_val = r_rd_val_q;
`else
  assign bm_mem_bm_cntl_rd_data     = r_rd_data;
  assign bm_mem_bm_cntl_rd_data_val = r_rd_val;
`endif

  assign bm_mem_col_valid = r_col_valid;
  assign bm_mem_err       = r_err;

endmodule

// File: tb/tb_bm_mem.sv
// tb/tb_bm_mem.sv - directed self-checking bench for bm_mem
module tb_bm_mem;
  import bm_mem_pkg::*;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         eng_rstn = 1'b1;
  logic         rd_rq = 1'b0;
  logic [1:0]   rd_addr = '0;
  logic [255:0] rd_data;
  logic         rd_val;
  logic         wr_en = 1'b0;
  logic [1:0]   wr_col = '0;
  logic [31:0]  wr_data = '0;
  logic         wr_abort = 1'b0;
  logic         wr_rdy;
  logic [3:0]   col_valid;
  logic         err_clr = 1'b0;
  logic [2:0]   err;

  int n_chk = 0;
  int n_bad = 0;

  logic [255:0] exp_b2b [4];

  localparam logic [255:0] COL2_EXP =
    256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;

  always #5 clk = ~clk;

  bm_mem dut (
    .clk                        (clk),
    .rstn                       (rstn),
    .eng_rstn                   (eng_rstn),
    .bm_cntl_bm_mem_rd_rq       (rd_rq),
    .bm_cntl_bm_mem_rd_addr     (rd_addr),
    .bm_mem_bm_cntl_rd_data     (rd_data),
    .bm_mem_bm_cntl_rd_data_val (rd_val),
    .host_bm_mem_wr_en          (wr_en),
    .host_bm_mem_wr_col         (wr_col),
    .host_bm_mem_wr_data        (wr_data),
    .host_bm_mem_wr_abort       (wr_abort),
    .bm_mem_host_wr_rdy         (wr_rdy),
    .bm_mem_col_valid           (col_valid),
    .host_bm_mem_err_clr        (err_clr),
    .bm_mem_err                 (err)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_col(input logic [31:0] base);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = base + 32'(i);
    return v;
  endfunction

  task automatic load_words(input logic [1:0] col, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_col  = col;
      wr_data = base + 32'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic load_col(input logic [1:0] col, input logic [31:0] base);
    load_words(col, base, 8);
    step();
  endtask

  task automatic read_col(input logic [1:0] a);
    rd_rq   = 1'b1;
    rd_addr = a;
    step();
    rd_rq   = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val",   rd_val,    0);
    chk("rst_data",  rd_data,   0);
    chk("rst_colv",  col_valid, 0);
    chk("rst_err",   err,       0);
    chk("rst_rdy",   wr_rdy,    1);
    rstn = 1'b1;
    step();

    read_col(2'd0);
    chk("unld_val",  rd_val,  1);
    chk("unld_data", rd_data, 0);
    chk("unld_err",  err,     3'b001);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_err0",  err,     0);

    load_words(2'd2, 32'h1, 8);
    chk("commit_rdy", wr_rdy, 0);
    step();
    chk("c2_colv",   col_valid, 4'b0100);
    chk("c2_rdy",    wr_rdy,    1);
    read_col(2'd2);
    chk("c2_val",    rd_val,  1);
    chk("c2_data",   rd_data, COL2_EXP);
    chk("c2_err",    err,     0);

    load_col(2'd0, 32'h100);
    load_col(2'd1, 32'h200);
    load_col(2'd3, 32'h300);
    chk("all_colv",  col_valid, 4'b1111);
    exp_b2b[0] = mk_col(32'h100);
    exp_b2b[1] = mk_col(32'h200);
    exp_b2b[2] = COL2_EXP;
    exp_b2b[3] = mk_col(32'h300);
    for (int a = 0; a < 4; a++) begin
      rd_rq   = 1'b1;
      rd_addr = 2'(a);
      step();
      chk("b2b_val",  rd_val,  1);
      chk("b2b_data", rd_data, exp_b2b[a]);
    end
    rd_rq = 1'b0;
    step();
    chk("idle_val",  rd_val,  0);
    chk("hold_data", rd_data, exp_b2b[3]);

    load_words(2'd1, 32'h400, 8);
    rd_rq   = 1'b1;
    rd_addr = 2'd1;
    wr_en   = 1'b1;
    wr_data = 32'hdead_beef;
    step();
    wr_en = 1'b0;
    chk("rc_old_val",  rd_val,  1);
    chk("rc_old_data", rd_data, mk_col(32'h200));
    chk("rc_rdy_err",  err,     3'b100);
    step();
    rd_rq = 1'b0;
    chk("rc_new_data", rd_data, mk_col(32'h400));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_err2",  err, 0);

    load_words(2'd1, 32'h500, 4);
    wr_en   = 1'b1;
    wr_col  = 2'd3;
    wr_data = 32'h5555_0004;
    step();
    wr_en = 1'b0;
    chk("chg_err",   err,    3'b010);
    chk("chg_rdy",   wr_rdy, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_err1",  err, 0);
    read_col(2'd1);
    chk("chg_keep",  rd_data, mk_col(32'h400));
    load_col(2'd1, 32'h800);
    read_col(2'd1);
    chk("chg_reload", rd_data, mk_col(32'h800));

    load_words(2'd3, 32'h600, 4);
    wr_abort = 1'b1;
    wr_en    = 1'b1;
    wr_data  = 32'hbad0_0000;
    step();
    wr_abort = 1'b0;
    wr_en    = 1'b0;
    load_col(2'd3, 32'h700);
    read_col(2'd3);
    chk("abort_data", rd_data, mk_col(32'h700));
    chk("abort_err",  err,     0);
    step();

    eng_rstn = 1'b0;
    rd_rq    = 1'b1;
    rd_addr  = 2'd2;
    step();
    chk("er_val",    rd_val,  0);
    chk("er_hold",   rd_data, mk_col(32'h700));
    eng_rstn = 1'b1;
    step();
    rd_rq = 1'b0;
    chk("er_rel_val",  rd_val,  1);
    chk("er_rel_data", rd_data, COL2_EXP);
    chk("er_colv",     col_valid, 4'b1111);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bm_mem.md
# bm_mem

Bitmatrix column memory: the responder side of the bitmatrix read interface driven by the engine's bitmatrix controller. It stores up to BM_MEM_DEPTH bitmatrix columns of BM_COL_W bits each and answers single-cycle read requests with a fixed-latency registered data/valid pair. Columns are loaded from the host control path as a sequence of HOST_DATA_W-bit words, assembled in a staging register, then committed atomically.

## Interface
- BM_COL_W, 256: column width (W*W*K_MAX).
- BM_MEM_DEPTH, 4: number of columns (M_MAX).
- BM_MEM_ADDR_W, 2: read/write column address width, at least clog2(BM_MEM_DEPTH).
- HOST_DATA_W, 32: host load word width; WORDS_PER_COL = ceil(BM_COL_W/HOST_DATA_W), 8 by default.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- eng_rstn  in  1  synchronous engine soft reset, active-low; flushes the read path only.
- bm_cntl_bm_mem_rd_rq  in  1  read request, one column per asserted cycle.
- bm_cntl_bm_mem_rd_addr  in  BM_MEM_ADDR_W  column to read.
- bm_mem_bm_cntl_rd_data  out  BM_COL_W  read data.
- bm_mem_bm_cntl_rd_data_val  out  1  one-cycle pulse per accepted request.
- host_bm_mem_wr_en  in  1  load word valid.
- host_bm_mem_wr_col  in  BM_MEM_ADDR_W  target column.
- host_bm_mem_wr_data  in  HOST_DATA_W  load word; word 0 holds column bits [HOST_DATA_W-1:0].
- host_bm_mem_wr_abort  in  1  discard the partial load.
- bm_mem_host_wr_rdy  out  1  load word accepted when wr_en and wr_rdy are both high.
- bm_mem_col_valid  out  BM_MEM_DEPTH  per-column "loaded" flags.
- host_bm_mem_err_clr  in  1  clears bm_mem_err.
- bm_mem_err  out  3  sticky flags: [0] read of an out-of-range or unloaded column, [1] wr_col changed mid-load, [2] wr_en while not ready.

## Operation
- Reset (rstn low): array, staging register, rd_data, rd_data_val, col_valid and err all clear to 0. FSM goes to IDLE and wr_rdy is 1.
- Read path:
  - A request sampled at edge N drives rd_data = array[rd_addr] and rd_data_val = 1 after edge N; otherwise val = 0 and rd_data holds.
  - Back-to-back requests are supported at one per cycle.
  - An address at or above BM_MEM_DEPTH returns zeros, still pulses val, and sets err[0].
  - A read of a column with col_valid = 0 returns the array content and sets err[0].
- eng_rstn low: requests are ignored, val is forced to 0 and rd_data holds. The load FSM, array and col_valid are unaffected.
- Load FSM:
  - IDLE: an accepted word latches wr_col, stores word 0 and sets word_cnt = 1. Next state is FILL, or COMMIT when WORDS_PER_COL == 1.
  - FILL: each accepted word is stored at slice word_cnt and word_cnt increments. After the word with index WORDS_PER_COL-1, go to COMMIT.
  - COMMIT: held for one cycle with wr_rdy = 0. The staging register is written to array[latched col] and col_valid[col] is set, then return to IDLE. Bits of the final word beyond BM_COL_W are dropped.
- Load error handling:
  - In FILL, a word whose wr_col differs from the latched column is dropped, sets err[1], and returns the FSM to IDLE.
  - wr_abort in IDLE or FILL returns the FSM to IDLE and discards the staging register; it has no effect in COMMIT. If wr_abort and wr_en are high together, the abort wins and the word is dropped.
  - wr_en while wr_rdy = 0 sets err[2].
- A load targeting an out-of-range column completes with no array write and sets err[0].
- err_clr clears all err bits. If err_clr and a new error occur in the same cycle, the error wins.

## Timing
- Read latency is 1 cycle from request to val (2 cycles with the macro enabled).
- Read and commit to the same column in the same cycle: the read returns the pre-commit (old) data. A read one cycle later returns the new data.
- Column load duration is WORDS_PER_COL accepted words plus 1 COMMIT cycle; the earliest next load word is the cycle after COMMIT.
- col_valid[c] rises the cycle after COMMIT and is cleared only by rstn.

## Configuration
- BM_MEM_RD_OUT_REG_EN defined: a second register stage is added on rd_data/val, so latency is 2 and throughput stays 1 per cycle. eng_rstn flushes both stages.
- BM_MEM_RD_OUT_REG_EN undefined: single stage, latency 1.

## Structure
- Shared package holds BM_COL_W, BM_MEM_DEPTH, BM_MEM_ADDR_W, HOST_DATA_W, the WORDS_PER_COL function, the load FSM state enum (IDLE, FILL, COMMIT) and the err bit index constants.
- One sub-module, bm_mem_col_loader, holds the FSM, staging register and word counter. It outputs a commit strobe, commit column and commit data. The top level holds the array, the read pipeline and the err/col_valid logic.

## Test plan
- Load column 2 with words 0x00000001..0x00000008, then read address 2: val one cycle later, rd_data equals the eight words concatenated with word 0 in the LSBs, col_valid = 4'b0100.
- Reads of 0,1,2,3 on consecutive cycles after full loads: four consecutive val pulses carrying the matching data, in order.
- Read of column 1 in the same cycle as the COMMIT of column 1: old data returned; a read on the next cycle returns the new data.
- Mid-load wr_col change from 1 to 3 at word 4: err[1] = 1, FSM back in IDLE, array[1] unchanged; err_clr drives bm_mem_err to 0.
- eng_rstn low while a request is pending: no val pulse; a loaded column is still readable after eng_rstn releases.
- Read of unloaded column 0 after reset: val = 1, rd_data = 0, err[0] = 1.
